// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, corrects ALU operands with
// EX/MEM and MEM/WB results, and detects load-use hazards against decode.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_rsData,
    input  logic [DATA_W-1:0] i_rtData,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [4:0]        i_shamt,
    input  logic [3:0]        i_ALUControl,
    input  logic              i_useImm,
    input  logic              i_regWrite,
    input  logic              i_memRead,
    input  logic              i_memWrite,
    input  logic              i_memToReg,
    input  logic              i_exmem_regWrite,
    input  logic [REG_W-1:0]  i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_regWrite,
    input  logic [REG_W-1:0]  i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [3:0]        o_ALUControl,
    output logic [4:0]        o_shiftAmount,
    output logic [DATA_W-1:0] o_storeData,
    output logic              o_valid,
    output logic [REG_W-1:0]  o_rd,
    output logic              o_regWrite,
    output logic              o_memRead,
    output logic              o_memWrite,
    output logic              o_memToReg,
    output logic              o_hazardStall
);

    logic              valid_q;
    logic [DATA_W-1:0] rs_val_q;
    logic [DATA_W-1:0] rt_val_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic [3:0]        alu_ctrl_q;
    logic              use_imm_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;

    logic              load_use;
    logic [DATA_W-1:0] rs_capture;
    logic [DATA_W-1:0] rt_capture;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // An immediate-form instruction only reads rt when it is a store.
    always_comb begin
        load_use = valid_q && mem_read_q && (rd_q != '0) && i_valid &&
                   ((rd_q == i_rs) ||
                    ((rd_q == i_rt) && (!i_useImm || i_memWrite)));
    end

    assign o_hazardStall = load_use && !i_stall && !i_reset;

    // The register file is written at the same edge we capture, so bypass it.
    always_comb begin
        rs_capture = i_rsData;
        rt_capture = i_rtData;
        if (i_memwb_regWrite && (i_memwb_rd == i_rs) && (i_rs != '0)) begin
            rs_capture = i_memwb_result;
        end
        if (i_memwb_regWrite && (i_memwb_rd == i_rt) && (i_rt != '0)) begin
            rt_capture = i_memwb_result;
        end
    end

    always_comb begin
        rs_fwd = rs_val_q;
        rt_fwd = rt_val_q;
        if (i_exmem_regWrite && (i_exmem_rd == rs_q) && (rs_q != '0)) begin
            rs_fwd = i_exmem_result;
        end else if (i_memwb_regWrite && (i_memwb_rd == rs_q) && (rs_q != '0)) begin
            rs_fwd = i_memwb_result;
        end
        if (i_exmem_regWrite && (i_exmem_rd == rt_q) && (rt_q != '0)) begin
            rt_fwd = i_exmem_result;
        end else if (i_memwb_regWrite && (i_memwb_rd == rt_q) && (rt_q != '0)) begin
            rt_fwd = i_memwb_result;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q      <= 1'b0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            alu_ctrl_q   <= '0;
            use_imm_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!i_stall) begin
            if (i_flush || load_use) begin
                // Bubble: operand fields are left as they were.
                valid_q      <= 1'b0;
                alu_ctrl_q   <= '0;
                reg_write_q  <= 1'b0;
                mem_read_q   <= 1'b0;
                mem_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
            end else begin
                valid_q      <= i_valid;
                rs_val_q     <= rs_capture;
                rt_val_q     <= rt_capture;
                rs_q         <= i_rs;
                rt_q         <= i_rt;
                rd_q         <= i_rd;
                imm_q        <= i_imm;
                shamt_q      <= i_shamt;
                alu_ctrl_q   <= i_ALUControl;
                use_imm_q    <= i_useImm;
                reg_write_q  <= i_regWrite && i_valid;
                mem_read_q   <= i_memRead && i_valid;
                mem_write_q  <= i_memWrite && i_valid;
                mem_to_reg_q <= i_memToReg && i_valid;
            end
        end
    end

    assign o_data1       = rs_fwd;
    assign o_data2       = use_imm_q ? imm_q : rt_fwd;
    assign o_storeData   = rt_fwd;
    assign o_ALUControl  = alu_ctrl_q;
    assign o_shiftAmount = shamt_q;
    assign o_valid       = valid_q;
    assign o_rd          = rd_q;
    assign o_regWrite    = reg_write_q;
    assign o_memRead     = mem_read_q;
    assign o_memWrite    = mem_write_q;
    assign o_memToReg    = mem_to_reg_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the ALU. It captures decoded instruction fields from the decode stage each cycle and presents `o_data1`, `o_data2`, `o_ALUControl` and `o_shiftAmount` to the ALU. Those operands are corrected with results forwarded from the EX/MEM and MEM/WB stages. It also generates the pipeline bubble and the stall request that a load-use dependency requires.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register-address width
- `i_clk`  in  1  clock, rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_stall`  in  1  downstream freeze; hold all stage registers
- `i_flush`  in  1  kill the instruction being captured (taken branch/jump)
- `i_valid`  in  1  decode slot holds a real instruction
- `i_rsData`, `i_rtData`  in  DATA_W  register-file read data
- `i_rs`, `i_rt`, `i_rd`  in  REG_W  source and destination register numbers (`i_rd` already muxed rt/rd)
- `i_imm`  in  DATA_W  sign-extended immediate
- `i_shamt`  in  5  shift amount
- `i_ALUControl`  in  4  ALU opcode (0000 ADD … 1001 NOR)
- `i_useImm`, `i_regWrite`, `i_memRead`, `i_memWrite`, `i_memToReg`  in  1  decoded control
- `i_exmem_regWrite`  in  1; `i_exmem_rd`  in  REG_W; `i_exmem_result`  in  DATA_W  EX/MEM forwarding source
- `i_memwb_regWrite`  in  1; `i_memwb_rd`  in  REG_W; `i_memwb_result`  in  DATA_W  MEM/WB forwarding source
- `o_data1`, `o_data2`  out  DATA_W  ALU operands
- `o_ALUControl`  out  4; `o_shiftAmount`  out  5  to ALU
- `o_storeData`  out  DATA_W  forwarded rt value for stores
- `o_valid`, `o_rd`, `o_regWrite`, `o_memRead`, `o_memWrite`, `o_memToReg`  out  stage contents passed to EX/MEM
- `o_hazardStall`  out  1  to PC/IF-ID: hold fetch and decode this cycle

## Operation
- **Stage registers:** valid, rsVal, rtVal, rs, rt, rd, imm, shamt, ALUControl, useImm and the four control bits.
- **Update priority at each rising edge:**
  - `i_reset` → clear all registers.
  - `i_stall` → hold all registers.
  - `i_flush` or `o_hazardStall` → load a bubble: valid and all control bits 0, ALUControl 0000, other fields don't-care.
  - Otherwise → capture the `i_*` fields, forcing control bits to 0 when `i_valid`=0.
- **Capture-time write-back bypass:**
  - If `i_memwb_regWrite` and `i_memwb_rd`==`i_rs`!=0, rsVal captures `i_memwb_result` instead of `i_rsData`.
  - The same rule applies to rt.
- **Forwarding:** combinational on the registered rs/rt.
  - For source X (rs or rt), fwd(X) = `i_exmem_result` if `i_exmem_regWrite` and `i_exmem_rd`==X!=0.
  - Otherwise, `i_memwb_result` if `i_memwb_regWrite` and `i_memwb_rd`==X!=0.
  - Otherwise, the registered value.
  - EX/MEM wins when both stages match.
- **Operand selection:**
  - `o_data1` = fwd(rs).
  - `o_data2` = useImm ? imm : fwd(rt).
  - `o_storeData` = fwd(rt) regardless of useImm.
- **Load-use detection (combinational):**
  - `o_hazardStall` = registered valid & memRead & rd!=0 & `i_valid` & (rd==`i_rs` | (rd==`i_rt` & (!`i_useImm` | `i_memWrite`))).
  - `o_hazardStall` is asserted only when the bubble will actually be loaded; it is forced to 0 while `i_stall`=1 or `i_reset`=1.
- **Register 0:** never forwarded, never hazards.

## Timing
- **Latency:** 1 cycle from decode inputs to registered stage fields.
- **Operand path:** `o_data1`/`o_data2`/`o_storeData` are combinational from stage registers plus the same-cycle forwarding inputs, with no additional latency.
- **Reset values:** every registered output is 0 (ALUControl=ADD), so `o_data1`/`o_data2` are 0 unless forwarding inputs are active.
- **Load-use penalty:** exactly one bubble; a load followed by a dependent instruction costs one cycle.
  - The next cycle the load is in EX/MEM, and the dependent instruction captures normally.
  - Its operand comes from MEM/WB forwarding one cycle later.
- **Simultaneous flush and hazard:** bubble; `o_hazardStall` still asserts for that cycle, which is harmless because IF/ID is being flushed.
- **Stall during flush:** `i_stall` dominates; the flush must be re-presented by its source.
- **Reset mid-operation:** the in-flight instruction is lost; the next capture occurs on the first edge with `i_reset`=0.

## Test plan
- **Reset:** assert reset 2 cycles with random inputs → all outputs 0 and `o_hazardStall`=0; release and capture ADD r3,r1,r2 (rsData=5, rtData=7) → `o_data1`=5, `o_data2`=7, `o_ALUControl`=0000.
- **Forwarding:**
  - EX/MEM rd=1, result=100 → `o_data1`=100.
  - Add MEM/WB rd=1, result=200 → still 100.
  - Drop EX/MEM → 200.
  - EX/MEM rd=0, regWrite=1 → registered value.
- **Load-use:** LW r4 in stage with next `i_rs`=4 → `o_hazardStall`=1; next cycle `o_valid`=0, `o_regWrite`=0; then the dependent instruction captures and `o_hazardStall`=0.
- **Immediate/store:**
  - ADDI with useImm=1, imm=0xFFFFFFF0, `i_rt`==load rd → no hazard.
  - SW with memWrite=1 → hazard; `o_storeData` gets the forwarded rt.
- **Flush and stall:** `i_flush`=1 → bubble; `i_stall`=1 for 3 cycles → outputs frozen and `o_hazardStall`=0; stall and flush together → hold.
- **Capture bypass:** `i_memwb_rd`=`i_rs`=6, result=0x55 while `i_rsData`=0 → after the edge, with no forwarding active, `o_data1`=0x55.
